// File: rtl/fact_accel_mmio.sv
// rtl/fact_accel_mmio.sv - memory-mapped iterative factorial accelerator with W1C status and irq
module fact_accel_mmio #(
   parameter int DATA_W = 32,
   parameter int N_W    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        A,
   input  logic              WE,
   input  logic [DATA_W-1:0] WD,
   output logic [DATA_W-1:0] RD,
   output logic              irq
);

   typedef enum logic {IDLE, CALC} state_t;

   localparam logic [N_W-1:0]    CNT_ONE = N_W'(1);
   localparam logic [DATA_W-1:0] ACC_ONE = DATA_W'(1);

   state_t              state, state_next;
   logic [N_W-1:0]      n_reg;
   logic [N_W-1:0]      cnt;
   logic [DATA_W-1:0]   acc;
   logic [DATA_W-1:0]   result;
   logic                ie, done, err;
   logic                busy;
   logic                go_wr;
   logic                last_step;
   logic [2*DATA_W-1:0] product;
   logic                unused_wd;

   assign busy      = (state == CALC);
   assign go_wr     = WE && (A == 2'd1) && WD[0];
   assign last_step = (cnt <= CNT_ONE);
   // Full-width product so the upper half exposes overflow of the truncated accumulator.
   assign product   = {{DATA_W{1'b0}}, acc} * {{(2*DATA_W-N_W){1'b0}}, cnt};
   assign irq       = ie & done;
   assign unused_wd = ^WD;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state: GO from IDLE starts, CALC ends once the counter reaches 1 or 0.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (go_wr) state_next = CALC;
         CALC: if (last_step) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Registers and datapath; hardware set of DONE/ERR is placed last so it beats a W1C in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         n_reg  <= '0;
         cnt    <= '0;
         acc    <= '0;
         result <= '0;
         ie     <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
      end else begin
         if (WE && (A == 2'd0) && !busy) n_reg <= WD[N_W-1:0];
         if (WE && (A == 2'd1)) ie <= WD[1];
         if (WE && (A == 2'd2)) begin
            if (WD[0]) done <= 1'b0;
            if (WD[1]) err  <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (go_wr) begin
                  cnt  <= n_reg;
                  acc  <= ACC_ONE;
                  done <= 1'b0;
                  err  <= 1'b0;
               end
            end
            CALC: begin
               if (last_step) begin
                  result <= acc;
                  done   <= 1'b1;
               end else begin
                  acc <= product[DATA_W-1:0];
                  if (|product[2*DATA_W-1:DATA_W]) err <= 1'b1;
                  cnt <= cnt - CNT_ONE;
               end
            end
            default: ;
         endcase
      end
   end

   // Read mux; every field is zero-extended to the bus width.
   always_comb begin
      RD = '0;
      case (A)
         2'd0: RD = DATA_W'(n_reg);
         2'd1: RD = DATA_W'({ie, 1'b0});
         2'd2: RD = DATA_W'({busy, err, done});
         2'd3: RD = result;
         default: RD = '0;
      endcase
   end

endmodule

// File: doc/fact_accel_mmio.md
Name: fact_accel_mmio

Overview:
- Parametrised, memory-mapped factorial accelerator; next generation of the SoC factorial peripheral.
- Sits on the MIPS SoC data bus beside dmem and gpio. Selected by the SoC address decoder: A comes from alu_out[3:2], WE from the decoder, WD from wd_dm. RD feeds the read-data mux.
- Adds over the previous generation: configurable result and operand widths, iterative one-multiply-per-cycle datapath with BUSY status, sticky overflow detection, write-1-to-clear status, interrupt output.

Parameters:
- DATA_W, 32, result/accumulator and bus width. Legal range 8..32.
- N_W, 4, operand width. Legal range 1..DATA_W.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst, input, 1, synchronous active-high reset.
- A, input, 2, register word select.
- WE, input, 1, write enable for this peripheral (already decoded).
- WD, input, DATA_W, write data.
- RD, output, DATA_W, read data (combinational from A and registers).
- irq, output, 1, interrupt request; level-high.

Behaviour:
- Register map (by A):
  - 0 N: read/write, low N_W bits; writes ignored while BUSY.
  - 1 CTRL: bit0 GO (write 1 = start; not stored; reads 0). bit1 IE (read/write).
  - 2 STATUS: bit0 DONE, bit1 ERR, bit2 BUSY. Writing 1 to bit0 or bit1 clears that bit (W1C); BUSY is read-only.
  - 3 RESULT: read-only, DATA_W bits.
- Reads zero-extend all fields to DATA_W. Writes to read-only fields have no effect.
- Reset (clk edge with rst=1) takes priority over any write: state=IDLE; N, IE, DONE, ERR, BUSY, RESULT, internal acc and cnt all 0. Therefore RD=0 for A=0..3 after reset, and irq=0.
- FSM has two states, IDLE and CALC. BUSY=1 exactly when state=CALC.
- IDLE, on a CTRL write with WD[0]=1:
  - cnt<=N, acc<=1, DONE<=0, ERR<=0, go to CALC.
  - If WD[1] is written in the same write, IE updates in that same edge.
- CALC, when cnt<=1: RESULT<=acc, DONE<=1, go to IDLE.
- CALC, otherwise:
  - Form the full 2*DATA_W product of acc and cnt.
  - acc<=low DATA_W bits of the product.
  - If any upper bits are nonzero, ERR<=1. ERR is sticky until the next GO or a W1C.
  - cnt<=cnt-1.
- Latency: if GO is written at edge k, DONE reads 1 after edge k+max(N,1).
  - N=0 or N=1 gives RESULT=1.
  - RESULT holds its previous value throughout CALC and changes only in the completion cycle.
- On overflow, RESULT is the product truncated modulo 2^DATA_W, with ERR=1.
- GO while BUSY is ignored: no restart, no flag change. Other fields of that CTRL write (IE) still apply.
- A STATUS W1C write to DONE in the same cycle that DONE sets: the set wins.
- irq = IE & DONE. It drops the cycle after a DONE W1C, after IE is cleared, or after a new GO.
- Reset asserted mid-CALC aborts the computation; everything returns to reset values next edge.
- Writes with WE=0 have no effect; reads have no side effects.

Test Plan:
1. Reset, then read A=0..3 -> all read 0; irq=0.
2. Write N=5, write CTRL=0x3 -> BUSY=1 for exactly 5 cycles. Then STATUS=0x1, RESULT=120, irq=1. Write STATUS=0x1 -> STATUS=0, irq=0, RESULT still 120.
3. DATA_W=32. N=12 -> RESULT=479001600 (0x1C8CFC00), ERR=0. N=13 -> RESULT=0x7328CC00 (6227020800 mod 2^32), STATUS=0x3.
4. DATA_W=16, N_W=4. N=8 -> RESULT=40320. N=9 -> ERR=1.
5. N=0 and N=1, each with GO -> DONE after 1 cycle, RESULT=1.
6. Start N=10, then 3 cycles later:
   - Write N=3 and GO=1 -> both ignored; final RESULT=3628800.
   - Separate run: assert rst during CALC -> the next read of every register is 0 and BUSY=0.
